// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-mux selects and
// the load-use stall FSM states.
package pipe_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } hz_state_e;

   // Width of the remaining-bubble counter; enough for LOAD_LAT up to 7.
   localparam int REM_W = 3;

endpackage

// File: rtl/fwd_select.sv
// Per-operand EX-stage forwarding select: the youngest producer (MEM) wins over
// WB, and the hard-wired zero register is never forwarded.
module fwd_select
   import pipe_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic [REG_AW-1:0] ex_reg_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic              mem_regwrite_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic              wb_regwrite_i,
   output fwd_sel_e          sel_o
);

   localparam logic [REG_AW-1:0] ZERO = REG_AW'(ZERO_REG);

   always_comb begin
      sel_o = FWD_RF;
      if (mem_regwrite_i && (mem_rd_i == ex_reg_i) && (mem_rd_i != ZERO)) begin
         sel_o = FWD_MEM;
      end else if (wb_regwrite_i && (wb_rd_i == ex_reg_i) && (wb_rd_i != ZERO)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: EX forwarding, load-use stall FSM, taken-branch
// flush/redirect and saturating stall/flush event counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 31,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rn,
   input  logic [REG_AW-1:0] id_rm,
   input  logic              id_use_rn,
   input  logic              id_use_rm,
   input  logic [REG_AW-1:0] ex_rn,
   input  logic [REG_AW-1:0] ex_rm,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   input  logic              br_taken,
   input  logic              cnt_clr,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              pc_en,
   output logic              pc_sel,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [REG_AW-1:0] ZERO    = REG_AW'(ZERO_REG);
   localparam logic [REM_W-1:0]  LAT_M1  = REM_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   logic [REG_AW-1:0] ex_src [2];
   fwd_sel_e          fwd_sel [2];

   hz_state_e         state_q, state_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              hz;
   logic              stall;

   assign ex_src[0] = ex_rn;
   assign ex_src[1] = ex_rm;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_select #(
         .REG_AW   (REG_AW),
         .ZERO_REG (ZERO_REG)
      ) u_fwd (
         .ex_reg_i       (ex_src[gi]),
         .mem_rd_i       (mem_rd),
         .mem_regwrite_i (mem_regwrite),
         .wb_rd_i        (wb_rd),
         .wb_regwrite_i  (wb_regwrite),
         .sel_o          (fwd_sel[gi])
      );
   end

   assign fwd_a = fwd_sel[0];
   assign fwd_b = fwd_sel[1];

   // A load into the zero register produces nothing worth waiting for.
   assign hz = ex_memread && (ex_rd != ZERO) &&
               ((id_use_rn && (id_rn == ex_rd)) || (id_use_rm && (id_rm == ex_rd)));

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      stall       = 1'b0;
      pc_en       = 1'b1;
      pc_sel      = 1'b0;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;

      // The stalled consumer is younger than the branch, so a redirect squashes it.
      if (br_taken) begin
         state_d     = RUN;
         rem_d       = '0;
         pc_sel      = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (hz) begin
                  stall = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = STALL;
                     rem_d   = LAT_M1;
                  end
               end
            end
            STALL: begin
               stall = 1'b1;
               rem_d = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
               rem_d   = '0;
            end
         endcase
      end

      if (stall) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (br_taken && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         rem_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations (LOAD_LAT=1, LOAD_LAT=3,
// CNT_W=2) share one stimulus stream and are checked against a bubble-count model.
module tb_pipe_hazard_ctrl;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
   logic       id_use_rn, id_use_rm, ex_memread, mem_regwrite, wb_regwrite;
   logic       br_taken, cnt_clr;

   logic [1:0]  fwd_a [NI];
   logic [1:0]  fwd_b [NI];
   logic        pc_en [NI];
   logic        pc_sel [NI];
   logic        ifid_en [NI];
   logic        ifid_flush [NI];
   logic        idex_flush [NI];
   logic        exmem_flush [NI];
   logic [31:0] stall_cnt [NI];
   logic [31:0] flush_cnt [NI];

   // Model: bubbles still owed after the current cycle, and event counts.
   int     left [NI];
   longint scnt [NI];
   longint fcnt [NI];
   int     lat  [NI] = '{1, 3, 1};
   longint cmax [NI] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int CW = (gi == 2) ? 2 : 32;
      logic [CW-1:0] sc, fc;
      pipe_hazard_ctrl #(
         .REG_AW   (5),
         .ZERO_REG (31),
         .LOAD_LAT ((gi == 1) ? 3 : 1),
         .CNT_W    (CW)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .id_rn        (id_rn),
         .id_rm        (id_rm),
         .id_use_rn    (id_use_rn),
         .id_use_rm    (id_use_rm),
         .ex_rn        (ex_rn),
         .ex_rm        (ex_rm),
         .ex_rd        (ex_rd),
         .ex_memread   (ex_memread),
         .mem_rd       (mem_rd),
         .mem_regwrite (mem_regwrite),
         .wb_rd        (wb_rd),
         .wb_regwrite  (wb_regwrite),
         .br_taken     (br_taken),
         .cnt_clr      (cnt_clr),
         .fwd_a        (fwd_a[gi]),
         .fwd_b        (fwd_b[gi]),
         .pc_en        (pc_en[gi]),
         .pc_sel       (pc_sel[gi]),
         .ifid_en      (ifid_en[gi]),
         .ifid_flush   (ifid_flush[gi]),
         .idex_flush   (idex_flush[gi]),
         .exmem_flush  (exmem_flush[gi]),
         .stall_cnt    (sc),
         .flush_cnt    (fc)
      );
      assign stall_cnt[gi] = 32'(sc);
      assign flush_cnt[gi] = 32'(fc);
   end

   function automatic bit hz_now();
      return ex_memread && (ex_rd != 5'd31) &&
             ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
   endfunction

   function automatic bit stalls(int i);
      return !br_taken && (left[i] > 0 || hz_now());
   endfunction

   function automatic logic [1:0] fwd_exp(logic [4:0] src);
      if (mem_regwrite && mem_rd == src && mem_rd != 5'd31) return 2'b10;
      if (wb_regwrite && wb_rd == src && wb_rd != 5'd31) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [9:0] exp_vec(int i);
      bit s;
      bit b;
      s = stalls(i);
      b = br_taken;
      return {fwd_exp(ex_rn), fwd_exp(ex_rm), b | ~s, b, ~s, b, b | s, b};
   endfunction

   function automatic logic [9:0] got_vec(int i);
      return {fwd_a[i], fwd_b[i], pc_en[i], pc_sel[i], ifid_en[i],
              ifid_flush[i], idex_flush[i], exmem_flush[i]};
   endfunction

   task automatic idle();
      id_rn = 0; id_rm = 0; ex_rn = 0; ex_rm = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      id_use_rn = 0; id_use_rm = 0; ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
      br_taken = 0; cnt_clr = 0;
   endtask

   task automatic set_load_use();
      ex_memread = 1; ex_rd = 5'd5; id_use_rm = 1; id_rm = 5'd5;
   endtask

   // Advance one clock and update the model with the inputs seen at the edge.
   task automatic tick();
      bit st [NI];
      bit b;
      bit c;
      for (int i = 0; i < NI; i++) st[i] = stalls(i);
      b = br_taken;
      c = cnt_clr;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         if (b) left[i] = 0;
         else if (left[i] > 0) left[i] = left[i] - 1;
         else if (st[i]) left[i] = lat[i] - 1;
         if (c) begin
            scnt[i] = 0;
            fcnt[i] = 0;
         end else begin
            if (st[i] && scnt[i] < cmax[i]) scnt[i] = scnt[i] + 1;
            if (b && fcnt[i] < cmax[i]) fcnt[i] = fcnt[i] + 1;
         end
      end
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         left[i] = 0; scnt[i] = 0; fcnt[i] = 0;
      end
      rst = 1;
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 0;
      #2;
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (got_vec(i) !== 10'b00_00_1_0_1_0_0_0)
            $display("FAIL reset_outputs inst%0d: got %b expected %b", i, got_vec(i), 10'b0000101000);
         else n_pass++;
         n_checks++;
         if (stall_cnt[i] !== 0 || flush_cnt[i] !== 0)
            $display("FAIL reset_counters inst%0d: got %0d/%0d expected 0/0", i, stall_cnt[i], flush_cnt[i]);
         else n_pass++;
      end
      $display("reset: outputs and counters checked");
      do_reset();
   endtask

   task automatic test_raw_forwarding();
      do_reset();
      mem_regwrite = 1; mem_rd = 3; ex_rn = 3; wb_regwrite = 1; wb_rd = 3;
      #1;
      n_checks++;
      if (fwd_a[0] !== 2'b10) $display("FAIL raw_mem_priority: got %b expected 10", fwd_a[0]);
      else n_pass++;
      mem_regwrite = 0;
      #1;
      n_checks++;
      if (fwd_a[0] !== 2'b01) $display("FAIL raw_wb: got %b expected 01", fwd_a[0]);
      else n_pass++;
      wb_regwrite = 0; ex_rm = 3;
      #1;
      n_checks++;
      if (fwd_a[0] !== 2'b00 || fwd_b[0] !== 2'b00)
         $display("FAIL raw_none: got %b/%b expected 00/00", fwd_a[0], fwd_b[0]);
      else n_pass++;
      $display("raw forwarding: mem>wb>rf sequence checked");
   endtask

   task automatic test_zero_reg();
      do_reset();
      mem_regwrite = 1; mem_rd = 31; ex_rm = 31; wb_regwrite = 1; wb_rd = 31;
      #1;
      n_checks++;
      if (fwd_b[0] !== 2'b00) $display("FAIL zero_fwd: got %b expected 00", fwd_b[0]);
      else n_pass++;
      idle();
      ex_memread = 1; ex_rd = 31; id_rn = 31; id_use_rn = 1;
      #1;
      n_checks++;
      if (pc_en[0] !== 1'b1 || idex_flush[0] !== 1'b0)
         $display("FAIL zero_no_stall: got pc_en=%b idex_flush=%b expected 1/0", pc_en[0], idex_flush[0]);
      else n_pass++;
      tick();
      n_checks++;
      if (stall_cnt[0] !== 0) $display("FAIL zero_stall_cnt: got %0d expected 0", stall_cnt[0]);
      else n_pass++;
      $display("zero register: no forward, no stall");
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use();
      #1;
      n_checks++;
      if ({pc_en[0], ifid_en[0], idex_flush[0]} !== 3'b001)
         $display("FAIL load_use_stall: got %b expected 001", {pc_en[0], ifid_en[0], idex_flush[0]});
      else n_pass++;
      tick();
      idle();
      #1;
      n_checks++;
      if (pc_en[0] !== 1'b1 || stall_cnt[0] !== 1)
         $display("FAIL load_use_release: got pc_en=%b stall_cnt=%0d expected 1/1", pc_en[0], stall_cnt[0]);
      else n_pass++;
      $display("load-use LOAD_LAT=1: single bubble");
   endtask

   task automatic test_long_load();
      int stalled;
      do_reset();
      stalled = 0;
      set_load_use();
      for (int k = 0; k < 6; k++) begin
         #1;
         n_checks++;
         if (pc_en[1] !== ((k < 3) ? 1'b0 : 1'b1))
            $display("FAIL long_load_cycle%0d: got pc_en=%b expected %b", k, pc_en[1], (k < 3) ? 1'b0 : 1'b1);
         else n_pass++;
         if (pc_en[1] === 1'b0) stalled++;
         tick();
         idle();
      end
      n_checks++;
      if (stalled != 3 || stall_cnt[1] !== 3)
         $display("FAIL long_load_total: got %0d cycles cnt=%0d expected 3/3", stalled, stall_cnt[1]);
      else n_pass++;
      set_load_use();
      tick();
      idle();
      br_taken = 1;
      #1;
      n_checks++;
      if ({pc_sel[1], pc_en[1], ifid_flush[1], idex_flush[1], exmem_flush[1]} !== 5'b11111)
         $display("FAIL long_load_flush: got %b expected 11111",
                  {pc_sel[1], pc_en[1], ifid_flush[1], idex_flush[1], exmem_flush[1]});
      else n_pass++;
      tick();
      br_taken = 0;
      #1;
      n_checks++;
      if (pc_en[1] !== 1'b1 || stall_cnt[1] !== 4 || flush_cnt[1] !== 1)
         $display("FAIL long_load_after_flush: got pc_en=%b stall=%0d flush=%0d expected 1/4/1",
                  pc_en[1], stall_cnt[1], flush_cnt[1]);
      else n_pass++;
      $display("load-use LOAD_LAT=3: three bubbles, branch cut");
   endtask

   task automatic test_branch_flush();
      do_reset();
      set_load_use();
      br_taken = 1;
      #1;
      n_checks++;
      if ({pc_sel[0], pc_en[0], ifid_flush[0], idex_flush[0], exmem_flush[0]} !== 5'b11111)
         $display("FAIL branch_flush: got %b expected 11111",
                  {pc_sel[0], pc_en[0], ifid_flush[0], idex_flush[0], exmem_flush[0]});
      else n_pass++;
      tick();
      idle();
      #1;
      n_checks++;
      if (flush_cnt[0] !== 1 || stall_cnt[0] !== 0 || pc_en[0] !== 1'b1)
         $display("FAIL branch_counts: got flush=%0d stall=%0d pc_en=%b expected 1/0/1",
                  flush_cnt[0], stall_cnt[0], pc_en[0]);
      else n_pass++;
      $display("branch with hazard: flush wins");
   endtask

   task automatic test_saturation();
      do_reset();
      set_load_use();
      for (int k = 0; k < 5; k++) tick();
      n_checks++;
      if (stall_cnt[2] !== 3 || stall_cnt[0] !== 5)
         $display("FAIL saturate: got %0d/%0d expected 3/5", stall_cnt[2], stall_cnt[0]);
      else n_pass++;
      cnt_clr = 1;
      tick();
      cnt_clr = 0;
      n_checks++;
      if (stall_cnt[2] !== 0 || stall_cnt[0] !== 0)
         $display("FAIL clear_wins: got %0d/%0d expected 0/0", stall_cnt[2], stall_cnt[0]);
      else n_pass++;
      $display("saturation and clear checked");
   endtask

   task automatic test_async_reset();
      do_reset();
      set_load_use();
      tick();
      idle();
      #1;
      n_checks++;
      if (pc_en[1] !== 1'b0 || stall_cnt[1] !== 1)
         $display("FAIL mid_stall_pre: got pc_en=%b cnt=%0d expected 0/1", pc_en[1], stall_cnt[1]);
      else n_pass++;
      rst = 0;
      #1;
      n_checks++;
      if (pc_en[1] !== 1'b1 || stall_cnt[1] !== 0 || flush_cnt[1] !== 0)
         $display("FAIL async_reset: got pc_en=%b cnt=%0d/%0d expected 1/0/0",
                  pc_en[1], stall_cnt[1], flush_cnt[1]);
      else n_pass++;
      do_reset();
      $display("async reset mid-stall checked");
   endtask

   task automatic test_random();
      int errs;
      do_reset();
      errs = 0;
      for (int k = 0; k < 400; k++) begin
         id_rn = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         id_rm = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         ex_rn = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         ex_rm = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         ex_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         mem_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         wb_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         id_use_rn = 1'($urandom); id_use_rm = 1'($urandom);
         ex_memread = 1'($urandom); mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
         br_taken = ($urandom_range(0, 7) == 0);
         cnt_clr = ($urandom_range(0, 31) == 0);
         #1;
         for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (got_vec(i) !== exp_vec(i)) begin
               errs++;
               $display("FAIL random_outputs cyc%0d inst%0d: got %b expected %b", k, i, got_vec(i), exp_vec(i));
            end else n_pass++;
         end
         tick();
         for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (stall_cnt[i] !== 32'(scnt[i]) || flush_cnt[i] !== 32'(fcnt[i])) begin
               errs++;
               $display("FAIL random_counters cyc%0d inst%0d: got %0d/%0d expected %0d/%0d",
                        k, i, stall_cnt[i], flush_cnt[i], scnt[i], fcnt[i]);
            end else n_pass++;
         end
      end
      $display("random: 400 cycles, %0d discrepancies", errs);
   endtask

   initial begin
      idle();
      rst = 0;
      test_reset();
      test_raw_forwarding();
      test_zero_reg();
      test_load_use();
      test_long_load();
      test_branch_flush();
      test_saturation();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
